// File: rtl/apb_pkg.sv
// Shared APB constants, register indices and FSM encoding.
// Imported by the register slave and its address decoder.
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int APB_SW = APB_DW / 8;

  localparam logic [3:0] REG_ID     = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/apb_reg_decode.sv
// Address and permission check for the register slave.
// Produces the word index, an in-map hit and the transfer error flag.
module apb_reg_decode
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [15:0] PRIV_MASK  = 16'h0
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [2:0]            pprot,
  output logic [3:0]            idx,
  output logic                  hit,
  output logic                  err
);

  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  logic ro;
  logic priv;
  logic unused_prot;

  assign unused_prot = ^pprot[2:1];

  // Word index, map hit, and write-protection faults.
  always_comb begin
    idx  = paddr[5:2];
    hit  = (paddr[1:0] == 2'b00) &&
           ({1'b0, idx} < NREGS) &&
           (paddr[ADDR_WIDTH-1:6] == '0);
    ro   = (idx == REG_ID) || (idx == REG_STATUS);
    priv = PRIV_MASK[idx] && !pprot[0];
    err  = !hit || (pwrite && (ro || priv));
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a small bank of 32-bit control/status registers.
// Wait states, byte strobes, and PSLVERR on bad or forbidden accesses.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  STROBE_WIDTH = 4,
  parameter int                  NUM_REGS     = 8,
  parameter int                  WAIT_STATES  = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
  parameter logic [15:0]         PRIV_MASK    = 16'h0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [STROBE_WIDTH-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  input  logic [DATA_WIDTH-1:0]          STATUS_in,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_out,
  output logic [NUM_REGS-1:0]            WR_pulse
);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [3:0]            dec_idx;
  logic                  dec_hit;
  logic                  dec_err;
  logic                  go_done;
  logic [3:0]            t_idx;
  logic                  t_wr;
  logic                  t_err;
  logic [DATA_WIDTH-1:0] rdata;

  apb_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .PRIV_MASK  (PRIV_MASK)
  ) u_dec (
    .paddr  (PADDR),
    .pwrite (PWRITE),
    .pprot  (PPROT),
    .idx    (dec_idx),
    .hit    (dec_hit),
    .err    (dec_err)
  );

  // Next-state, completion response and register write commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    pulse_d   = '0;
    regs_d    = regs_q;
    go_done   = 1'b0;
    t_idx     = idx_q;
    t_wr      = wr_q;
    t_err     = err_q;
    rdata     = '0;

    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = dec_idx;
          wr_d    = PWRITE;
          err_d   = dec_err || !dec_hit;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = 4'(WAIT_STATES);
          t_idx   = dec_idx;
          t_wr    = PWRITE;
          t_err   = dec_err || !dec_hit;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
            go_done = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (PSEL && PENABLE && wr_q && !err_q) begin
          for (int i = 2; i < NUM_REGS; i++) begin
            if (idx_q == 4'(i)) begin
              for (int b = 0; b < STROBE_WIDTH; b++) begin
                if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
              end
              pulse_d[i] = |strb_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (t_idx == REG_ID) begin
      rdata = ID_VALUE;
    end else if (t_idx == REG_STATUS) begin
      rdata = STATUS_in;
    end else begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (t_idx == 4'(i)) rdata = regs_q[i];
      end
    end

    if (go_done) begin
      pready_d  = 1'b1;
      pslverr_d = t_err;
      prdata_d  = (t_err || t_wr) ? '0 : rdata;
    end
  end

  // State, latched transfer, registered outputs and register bank.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign WR_pulse = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign REGS_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: two instances (0 and 3 wait states).
// Expected responses are queued at setup and popped at PREADY.
module tb_apb_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [31:0]  status;

  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1;
  logic         perr0, perr1;
  logic [255:0] regs0, regs1;
  logic [7:0]   pulse0, pulse1;

  apb_reg_slave u0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .STATUS_in(status), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(perr0), .REGS_out(regs0),
    .WR_pulse(pulse0)
  );

  apb_reg_slave #(
    .WAIT_STATES(3),
    .PRIV_MASK(16'h0004)
  ) u1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .STATUS_in(status), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(perr1), .REGS_out(regs1),
    .WR_pulse(pulse1)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves at the falling edge after DONE.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] st,
                      input logic [2:0] pr, input logic [31:0] erd,
                      input logic eerr, input logic [7:0] epulse);
    exp_t e;
    int   waits;
    logic done;
    e.rd  = erd;
    e.err = eerr;
    sb.push_back(e);
    psel    = (d != 0) ? 2'b10 : 2'b01;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = dat;
    pstrb   = st;
    pprot   = pr;
    @(negedge clk);
    penable = 1'b1;
    waits   = 0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (((d != 0) ? pready1 : pready0) === 1'b1) begin
        done = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    chk($sformatf("ready a=%h", a), 256'(done), 256'(1));
    e = sb.pop_front();
    if (done) begin
      chk($sformatf("prdata a=%h", a),
          256'((d != 0) ? prdata1 : prdata0), 256'(e.rd));
      chk($sformatf("pslverr a=%h", a),
          256'((d != 0) ? perr1 : perr0), 256'(e.err));
      chk($sformatf("waits a=%h", a), 256'(waits),
          256'((d != 0) ? 3 : 0));
    end
    @(negedge clk);
    psel    = 2'b00;
    penable = 1'b0;
    chk($sformatf("wr_pulse a=%h", a),
        256'((d != 0) ? pulse1 : pulse0), 256'(epulse));
    chk($sformatf("ready_low a=%h", a),
        256'((d != 0) ? pready1 : pready0), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ev;
    rst     = 1'b1;
    psel    = 2'b00;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    status  = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst regs0", regs0, '0);
    chk("rst regs1", regs1, '0);
    chk("rst outs0", 256'({prdata0, pready0, perr0, pulse0}), '0);
    chk("rst outs1", 256'({prdata1, pready1, perr1, pulse1}), '0);

    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 32'hA9B0_0001, 1'b0, 8'h00);
    xfer(0, 1'b1, 32'h08, 32'h1234_5678, 4'b0101, 3'b000, 32'h0, 1'b0, 8'h04);
    ev = '0;
    ev[95:64] = 32'h0034_0078;
    chk("strb write regs0", regs0, ev);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h0034_0078, 1'b0, 8'h00);

    xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b0, 32'h09, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b1, 32'h40, 32'h1, 4'hF, 3'b000, 32'h0, 1'b1, 8'h00);
    xfer(0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 3'b000, 32'h0, 1'b0, 8'h00);
    chk("no change regs0", regs0, ev);

    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0BAD_F00D, 1'b0, 8'h00);
    status = 32'hDEAD_BEEF;
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, 1'b0, 8'h00);

    xfer(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, 1'b0, 8'h08);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 8'h00);

    xfer(1, 1'b1, 32'h08, 32'h1122_3344, 4'hF, 3'b000, 32'h0, 1'b1, 8'h00);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 8'h00);
    xfer(1, 1'b1, 32'h08, 32'h1122_3344, 4'hF, 3'b001, 32'h0, 1'b0, 8'h04);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h1122_3344, 1'b0, 8'h00);

    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hAAAA_5555;
    pstrb   = 4'hF;
    pprot   = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel    = 2'b00;
    penable = 1'b0;
    @(negedge clk);
    chk("abort state", 256'(u1.state_q), 256'(2'b00));
    repeat (4) @(negedge clk);
    chk("abort ready", 256'(pready1), 256'(0));
    chk("abort pulse", 256'(pulse1), 256'(0));
    chk("abort reg4", 256'(regs1[159:128]), 256'(0));

    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h14;
    pwdata  = 32'h0000_0055;
    pstrb   = 4'hF;
    pprot   = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("pre-rst state", 256'(u1.state_q), 256'(2'b01));
    rst = 1'b1;
    #1;
    chk("mid-rst state", 256'(u1.state_q), 256'(2'b00));
    chk("mid-rst ready", 256'(pready1), 256'(0));
    @(negedge clk);
    rst     = 1'b0;
    psel    = 2'b00;
    penable = 1'b0;
    @(negedge clk);
    chk("post-rst regs1", regs1, '0);
    chk("post-rst regs0", regs0, '0);
    chk("post-rst pulse", 256'(pulse1), 256'(0));

    xfer(1, 1'b1, 32'h14, 32'h0000_0055, 4'hF, 3'b000, 32'h0, 1'b0, 8'h20);
    xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000, 32'h0000_0055, 1'b0, 8'h00);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
